// File: rtl/event_change_collector.sv
// event_change_collector
// Samples four buses every clock, flags which of them changed since the
// previous sample and queues a {mask, (a&b)|(c&d)} record in a small FIFO
// drained through a valid/ready handshake. Overflowing records are counted
// in a saturating drop counter.
module event_change_collector #(
  parameter int W     = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  input  logic [W-1:0]             c,
  input  logic [W-1:0]             d,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [3:0]               evt_mask,
  output logic [W-1:0]             evt_out,
  output logic [$clog2(DEPTH):0]   evt_level,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 4 + W;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Sampled history of the monitored buses
  logic [W-1:0]     prev_a_q, prev_b_q, prev_c_q, prev_d_q;
  logic             primed_q;

  // FIFO storage and bookkeeping
  logic [RW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  // Per-cycle decode
  logic [3:0]       mask_s;
  logic [W-1:0]     out_s;
  logic             pop_s;
  logic             full_s;
  logic             push_req_s;
  logic             push_ok_s;
  logic             drop_s;

  // Change detection, record value and FIFO push/pop/drop decisions
  always_comb begin
    mask_s     = {(d != prev_d_q), (c != prev_c_q), (b != prev_b_q), (a != prev_a_q)};
    out_s      = (a & b) | (c & d);
    pop_s      = (level_q != {LW{1'b0}}) && evt_ready;
    full_s     = (level_q == FULL_LVL);
    // The first sample after reset only establishes history.
    push_req_s = primed_q && (mask_s != 4'b0000);
    // A pop at the same edge frees the slot the push needs.
    push_ok_s  = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
  end

  // Next-state for pointers, occupancy and drop counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Clearing takes precedence over a coincident drop.
    if (clr_drop) begin
      drop_d = {CNT_W{1'b0}};
    end else if (drop_s && (drop_q != CNT_MAX)) begin
      drop_d = drop_q + CNT_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a_q <= {W{1'b0}};
      prev_b_q <= {W{1'b0}};
      prev_c_q <= {W{1'b0}};
      prev_d_q <= {W{1'b0}};
      primed_q <= 1'b0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      drop_q   <= {CNT_W{1'b0}};
    end else begin
      prev_a_q <= a;
      prev_b_q <= b;
      prev_c_q <= c;
      prev_d_q <= d;
      primed_q <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Record storage; contents are only observed while the slot is occupied
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) begin
      mem_q[wr_ptr_q] <= {mask_s, out_s};
    end
  end

  // Head-of-queue view, forced to zero while the FIFO is empty
  always_comb begin
    evt_valid = (level_q != {LW{1'b0}});
    if (evt_valid) begin
      evt_mask = mem_q[rd_ptr_q][RW-1:W];
      evt_out  = mem_q[rd_ptr_q][W-1:0];
    end else begin
      evt_mask = 4'b0000;
      evt_out  = {W{1'b0}};
    end
    evt_level = level_q;
    drop_cnt  = drop_q;
  end

endmodule

// File: tb/tb_event_change_collector.sv
// Self-checking bench for event_change_collector: directed test-plan
// scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a queue-based behavioural model.
module tb_event_change_collector;

  localparam int W     = 1;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic         evt_ready = 1'b0;
  logic         clr_drop  = 1'b0;

  logic         v8, v2;
  logic [3:0]   m8, m2;
  logic [W-1:0] o8, o2;
  logic [2:0]   l8, l2;
  logic [7:0]   dc8;
  logic [1:0]   dc2;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [4+W-1:0] q[$];
  logic [W-1:0]   pa, pb, pc, pd;
  bit             primed;
  int             drop8, drop2;

  always #5 clk = ~clk;

  event_change_collector #(.W(W), .DEPTH(DEPTH), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .evt_valid(v8), .evt_ready(evt_ready), .evt_mask(m8), .evt_out(o8),
    .evt_level(l8), .drop_cnt(dc8), .clr_drop(clr_drop));

  event_change_collector #(.W(W), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .evt_valid(v2), .evt_ready(evt_ready), .evt_mask(m2), .evt_out(o2),
    .evt_level(l2), .drop_cnt(dc2), .clr_drop(clr_drop));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, using the values presented before the edge
  task automatic model_step();
    logic [3:0] mask;
    bit         pop, drop;
    if (rst) begin
      q.delete();
      pa = '0; pb = '0; pc = '0; pd = '0;
      primed = 1'b0;
      drop8 = 0; drop2 = 0;
    end else begin
      pop  = (q.size() > 0) && evt_ready;
      mask = {d != pd, c != pc, b != pb, a != pa};
      drop = 1'b0;
      if (pop) void'(q.pop_front());
      if (primed && mask != 4'b0000) begin
        if (q.size() < DEPTH) q.push_back({mask, (a & b) | (c & d)});
        else drop = 1'b1;
      end
      if (clr_drop) begin
        drop8 = 0; drop2 = 0;
      end else if (drop) begin
        if (drop8 < 255) drop8++;
        if (drop2 < 3) drop2++;
      end
      pa = a; pb = b; pc = c; pd = d;
      primed = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare both DUTs against the model every cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid8", 32'(v8), 32'(q.size() != 0));
      check("valid2", 32'(v2), 32'(q.size() != 0));
      check("level8", 32'(l8), 32'(q.size()));
      check("level2", 32'(l2), 32'(q.size()));
      check("drop8",  32'(dc8), 32'(drop8));
      check("drop2",  32'(dc2), 32'(drop2));
      if (q.size() != 0) begin
        check("head8", 32'({m8, o8}), 32'(q[0]));
        check("head2", 32'({m2, o2}), 32'(q[0]));
      end
    end
  end

  initial begin
    logic [W-1:0] exp_out [4];
    exp_out[0] = 1'b1; exp_out[1] = 1'b0; exp_out[2] = 1'b1; exp_out[3] = 1'b0;

    // Reset with toggling inputs
    rst = 1'b1;
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b0;
    tick();
    cmp_en = 1'b1;
    a = 1'b0; b = 1'b1; c = 1'b0; d = 1'b1;
    tick();
    check("rst_valid", 32'(v8), 32'd0);
    check("rst_level", 32'(l8), 32'd0);
    check("rst_drop",  32'(dc8), 32'd0);
    check("rst_mask",  32'(m8), 32'd0);
    check("rst_out",   32'(o8), 32'd0);

    // First edge after release only primes
    rst = 1'b0; a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1;
    tick();
    check("prime_no_rec", 32'(v8), 32'd0);

    // Re-prime with all zeros, then single event a,b
    rst = 1'b1; tick();
    rst = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0; tick();
    a = 1'b1; b = 1'b1; tick();
    check("single_valid", 32'(v8), 32'd1);
    check("single_mask",  32'(m8), 32'b0011);
    check("single_out",   32'(o8), 32'd1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("single_popped", 32'(v8), 32'd0);
    check("single_level",  32'(l8), 32'd0);

    // Set up a=b=0, c=1 and drain that record
    a = 1'b0; b = 1'b0; c = 1'b1; tick();
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // Overflow: six d toggles with no consumer
    for (int i = 0; i < 6; i++) begin
      d = ~d; tick();
    end
    check("ovf_level", 32'(l8), 32'd4);
    check("ovf_drop",  32'(dc8), 32'd2);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_mask", 32'(m8), 32'b1000);
      check("drain_out",  32'(o8), 32'(exp_out[i]));
      tick();
    end
    check("drain_empty", 32'(v8), 32'd0);

    // Full with simultaneous pop and push
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = ~d; tick();
    end
    evt_ready = 1'b1; a = 1'b1; tick();
    check("fullpop_level", 32'(l8), 32'd4);
    check("fullpop_drop",  32'(dc8), 32'd2);
    tick(); tick(); tick();
    check("fullpop_last_mask", 32'(m8), 32'b0001);
    check("fullpop_last_out",  32'(o8), 32'd0);
    tick();
    check("fullpop_empty", 32'(v8), 32'd0);

    // Mid-operation reset with three queued records
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = ~d; tick();
    end
    check("mid_level3", 32'(l8), 32'd3);
    rst = 1'b1; tick();
    check("mid_rst_valid", 32'(v8), 32'd0);
    check("mid_rst_level", 32'(l8), 32'd0);
    rst = 1'b0; a = ~a; b = ~b; tick();
    check("mid_prime_valid", 32'(v8), 32'd0);

    // Saturation and clear-wins-over-drop
    for (int i = 0; i < 9; i++) begin
      d = ~d; tick();
    end
    check("sat_drop2", 32'(dc2), 32'd3);
    check("sat_drop8", 32'(dc8), 32'd5);
    clr_drop = 1'b1; d = ~d; tick(); clr_drop = 1'b0;
    check("clr_drop2", 32'(dc2), 32'd0);
    check("clr_drop8", 32'(dc8), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clr_drop  = ($urandom_range(0, 49) == 0);
      evt_ready = ($urandom_range(0, 2) != 0) ? ($urandom_range(0, 1) == 1) : evt_ready;
      if ($urandom_range(0, 2) == 0) a = ~a;
      if ($urandom_range(0, 2) == 0) b = ~b;
      if ($urandom_range(0, 2) == 0) c = ~c;
      if ($urandom_range(0, 2) == 0) d = ~d;
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
